uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
- 8N1 UART receiver that deserializes a serial line into bytes presented on a valid/ready interface.
- It is the receive end of the SoC's serial port. It is instanced in the board top to monitor the line driven by the SoC's uart_tx, or to accept host traffic arriving on uart_rx, and feed it to on-chip logic such as the LED/debug path.
- It runs on the PLL-derived system clock (55 MHz nominal). It uses the codebase's counted power-on reset, applied asynchronously.

Parameters:
- CLK_HZ, 55000000: frequency of clock in Hz.
- BAUD, 115200: line rate in bit/s.
- CLKS_PER_BIT, CLK_HZ/BAUD (truncating, 477 at defaults): clocks per bit. Elaboration error if < 4.

Ports:
- clock, in, 1: system clock; all state on posedge.
- reset, in, 1: asynchronous, active-high reset; forces all state to reset values immediately.
- rx, in, 1: asynchronous serial input; idle high.
- data, out, 8: received byte; LSB is first bit on wire.
- valid, out, 1: data holds an unconsumed byte.
- ready, in, 1: consumer accepts data when valid && ready at posedge.
- busy, out, 1: high in any state other than IDLE.
- frame_err, out, 1: one-cycle pulse when the stop bit samples low.
- overrun, out, 1: one-cycle pulse when a good byte is dropped because the output is still full.

Behaviour:
- Input sync:
  - rx passes through 2 flops (sync1, sync2), both reset to 1. rx_s = sync2.
  - All decisions use rx_s; pin-to-rx_s latency is 2 clocks.
- HALF = CLKS_PER_BIT/2 (truncating).
- cnt is a bit-period counter, width clog2(CLKS_PER_BIT). bitn is a 3-bit index. sh is an 8-bit shift register.
- States: WAIT_HIGH, IDLE, START, DATA, STOP. Reset state is WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then IDLE. This prevents a low line at reset release or after a break from being taken as a start bit.
- IDLE: if rx_s==0, go to START with cnt=0.
- START:
  - cnt increments each clock.
  - When cnt==HALF-1: if rx_s==0, go to DATA with cnt=0 and bitn=0.
  - If rx_s==1 at that point, it is a glitch: return to IDLE and raise no flag.
- DATA:
  - When cnt==CLKS_PER_BIT-1: sh <= {rx_s, sh[7:1]} and cnt=0.
  - If bitn==7, go to STOP; otherwise bitn++.
- STOP: when cnt==CLKS_PER_BIT-1, sample rx_s.
  - rx_s==1, output free (valid==0, or ready==1 this cycle): data<=sh, valid<=1. Go to IDLE.
  - rx_s==1, output full (valid && !ready): data and valid unchanged, overrun pulses. Go to IDLE.
  - rx_s==0: frame_err pulses and the byte is discarded. Go to WAIT_HIGH.
- Output handshake:
  - valid clears on the posedge where valid && ready, unless a new byte loads on that same edge; then valid stays 1 with the new data.
  - data is stable while valid && !ready.
- Latency: valid rises on the edge after the STOP sample edge. That is 2 + HALF + 9*CLKS_PER_BIT + 1 clocks after the rx falling edge (±1 for sync phase).
- Reset values: data=0, valid=0, frame_err=0, overrun=0, busy=1 (WAIT_HIGH), cnt=0, bitn=0, sh=0.
- Reset mid-frame aborts the frame with no flag. After release, the block waits for a high line.
- frame_err and overrun never assert in the same cycle. Neither is sticky.
- Back-to-back frames: a start bit immediately following the stop-bit sample is accepted from IDLE. The half-bit remaining of the stop bit is absorbed by the idle-high check.

Decomposition:
- Package uart_pkg holds:
  - the rx_state_t enum (WAIT_HIGH, IDLE, START, DATA, STOP);
  - the function clks_per_bit(clk_hz, baud) with truncation;
  - the constant UART_DATA_BITS = 8.
- One sub-module, sync_2ff: 2-flop synchronizer with reset value parameter INIT=1, reset asynchronous. It is reused for other async pins in chip_top.

Test Plan (CLK_HZ=1000000, BAUD=100000, giving CLKS_PER_BIT=10, HALF=5):
- Hold rx=1, assert reset 3 cycles, release. Then send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) with ready=1. Required: valid pulses for 1 cycle with data=0xA5 about 98 clocks after the start edge; frame_err=0, overrun=0.
- Send 0x3C then 0xC3 back-to-back with ready=0. Then send 0xFF still with ready=0. Required: data=0x3C, valid=1, and overrun pulses once (at the 0xC3 stop sample, dropping 0xC3); 0xFF also drops with a second overrun pulse. Raising ready clears valid the next cycle.
- Drive rx low for 3 clocks, then high. Required: the block returns to IDLE; no valid, no frame_err; busy high for at most HALF+2 clocks.
- Send 0x55 with stop bit=0, then hold rx low 50 clocks. Required: frame_err one pulse, valid stays 0, state stays WAIT_HIGH until rx goes high. A following 0x12 frame is received correctly.
- Assert reset at bit 4 of a frame while rx=0, then release. Required: all outputs at reset values; no byte is produced from the aborted frame; the next full 0x81 frame is received.
- Hold valid=1 and assert ready on the exact cycle the next good stop sample lands (byte 0x7E). Required: valid stays 1, data=0x7E, no overrun.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and helpers.
// Used by the receiver and other serial-port blocks.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      WAIT_HIGH,
      IDLE,
      START,
      DATA,
      STOP
   } rx_state_t;

   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous input pins.
// INIT sets the value both flops take during reset.
module sync_2ff #(
   parameter bit INIT = 1'b1
) (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic s1;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1 <= INIT;
         q  <= INIT;
      end else begin
         s1 <= d;
         q  <= s1;
      end
   end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with a valid/ready byte output.
// Start bit is re-checked at half-bit; data bits are sampled mid-bit.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int CLK_HZ       = 55000000,
   parameter int BAUD         = 115200,
   parameter int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      rx,
   output logic [UART_DATA_BITS-1:0] data,
   output logic                      valid,
   input  logic                      ready,
   output logic                      busy,
   output logic                      frame_err,
   output logic                      overrun
);

   generate
      if (CLKS_PER_BIT < 4) begin : g_bad_rate
         $error("uart_rx_core: CLKS_PER_BIT must be at least 4");
      end
   endgenerate

   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam int HALF = CLKS_PER_BIT / 2;

   localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
   localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

   logic rx_s;

   rx_state_t                 state, state_n;
   logic [CW-1:0]             cnt, cnt_n;
   logic [2:0]                bitn, bitn_n;
   logic [UART_DATA_BITS-1:0] sh, sh_n;
   logic [UART_DATA_BITS-1:0] data_n;
   logic                      valid_n;
   logic                      ferr_n;
   logic                      ovr_n;
   logic                      bit_end;

   sync_2ff #(
      .INIT(1'b1)
   ) u_sync (
      .clock(clock),
      .reset(reset),
      .d    (rx),
      .q    (rx_s)
   );

   assign busy    = (state != IDLE);
   assign bit_end = (cnt == BIT_END);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= WAIT_HIGH;
         cnt       <= '0;
         bitn      <= '0;
         sh        <= '0;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         bitn      <= bitn_n;
         sh        <= sh_n;
         data      <= data_n;
         valid     <= valid_n;
         frame_err <= ferr_n;
         overrun   <= ovr_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      bitn_n  = bitn;
      sh_n    = sh;
      data_n  = data;
      valid_n = valid && !ready;
      ferr_n  = 1'b0;
      ovr_n   = 1'b0;

      unique case (state)
         WAIT_HIGH: begin
            if (rx_s) state_n = IDLE;
         end
         IDLE: begin
            if (!rx_s) begin
               state_n = START;
               cnt_n   = '0;
            end
         end
         START: begin
            if (cnt == HALF_END) begin
               cnt_n = '0;
               if (!rx_s) begin
                  state_n = DATA;
                  bitn_n  = '0;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_n = '0;
               sh_n  = {rx_s, sh[UART_DATA_BITS-1:1]};
               if (bitn == LAST_BIT) state_n = STOP;
               else bitn_n = bitn + 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               cnt_n = '0;
               if (rx_s) begin
                  state_n = IDLE;
                  // A slot freed by this edge's handshake may take the byte
                  if (!valid || ready) begin
                     data_n  = sh;
                     valid_n = 1'b1;
                  end else begin
                     ovr_n = 1'b1;
                  end
               end else begin
                  state_n = WAIT_HIGH;
                  ferr_n  = 1'b1;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = WAIT_HIGH;
      endcase
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core at 10 clocks per bit.
// Table vectors, directed corner sequences and random frames.
module tb_uart_rx_core;

   localparam int CPB  = 10;
   localparam int HALF = CPB / 2;

   typedef struct {
      logic [7:0] b;
      logic       stop;
      int         exp_acc;
      int         exp_ferr;
   } vec_t;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       rx    = 1'b1;
   logic       ready = 1'b0;
   logic [7:0] data;
   logic       valid;
   logic       busy;
   logic       frame_err;
   logic       overrun;

   int errors = 0;
   int checks = 0;
   int vcyc   = 0;
   int nferr  = 0;
   int novr   = 0;
   int nboth  = 0;
   logic [7:0] got[$];

   uart_rx_core #(
      .CLK_HZ(1000000),
      .BAUD  (100000)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .rx       (rx),
      .data     (data),
      .valid    (valid),
      .ready    (ready),
      .busy     (busy),
      .frame_err(frame_err),
      .overrun  (overrun)
   );

   always #5 clock = ~clock;

   // Inputs change 2 units after posedge, so negedge sees next-edge values
   always @(negedge clock) begin
      if (!reset) begin
         if (valid) vcyc++;
         if (valid && ready) got.push_back(data);
         if (frame_err) nferr++;
         if (overrun) novr++;
         if (frame_err && overrun) nboth++;
      end
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) tick();
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      repeat (CPB) tick();
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) tick();
      end
      rx = stop;
      repeat (CPB) tick();
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                  name, act, act, exp, exp);
      end
   endtask

   initial begin
      vec_t       tbl[5];
      int         g0, f0, o0, v0, n, bl, efe;
      logic [7:0] b;
      logic       st;
      logic [7:0] expq[$];

      tbl[0] = '{8'hA5, 1'b1, 1, 0};
      tbl[1] = '{8'h00, 1'b1, 1, 0};
      tbl[2] = '{8'hFF, 1'b1, 1, 0};
      tbl[3] = '{8'h55, 1'b0, 0, 1};
      tbl[4] = '{8'h12, 1'b1, 1, 0};

      // Reset values
      rx    = 1'b1;
      reset = 1'b1;
      repeat (3) tick();
      check("rst_data", int'(data), 0);
      check("rst_valid", int'(valid), 0);
      check("rst_busy", int'(busy), 1);
      check("rst_ferr", int'(frame_err), 0);
      check("rst_ovr", int'(overrun), 0);
      reset = 1'b0;
      idle(5);
      check("idle_busy", int'(busy), 0);

      // Latency of a single 0xA5 frame
      ready = 1'b1;
      g0 = got.size(); f0 = nferr; o0 = novr; v0 = vcyc;
      n = 0;
      fork
         send_frame(8'hA5, 1'b1);
         begin
            while (n < 200 && !valid) begin
               tick();
               n++;
            end
         end
      join
      idle(20);
      check("lat_range", int'(n >= 97 && n <= 99), 1);
      check("lat_vcyc", vcyc - v0, 1);
      check("lat_cnt", got.size() - g0, 1);
      if (got.size() > g0) check("lat_data", int'(got[g0]), 8'hA5);
      check("lat_ferr", nferr - f0, 0);
      check("lat_ovr", novr - o0, 0);

      // Table vectors, consumer always ready
      foreach (tbl[i]) begin
         g0 = got.size(); f0 = nferr; o0 = novr;
         send_frame(tbl[i].b, tbl[i].stop);
         idle(15);
         check($sformatf("tbl%0d_cnt", i), got.size() - g0, tbl[i].exp_acc);
         if (tbl[i].exp_acc == 1 && got.size() > g0)
            check($sformatf("tbl%0d_data", i), int'(got[g0]), int'(tbl[i].b));
         check($sformatf("tbl%0d_ferr", i), nferr - f0, tbl[i].exp_ferr);
         check($sformatf("tbl%0d_ovr", i), novr - o0, 0);
      end

      // Overrun: output held full across three frames
      ready = 1'b0;
      g0 = got.size(); f0 = nferr; o0 = novr;
      send_frame(8'h3C, 1'b1);
      send_frame(8'hC3, 1'b1);
      send_frame(8'hFF, 1'b1);
      idle(15);
      check("ovr_valid", int'(valid), 1);
      check("ovr_data", int'(data), 8'h3C);
      check("ovr_pulses", novr - o0, 2);
      check("ovr_ferr", nferr - f0, 0);
      ready = 1'b1;
      tick();
      check("ovr_drain_valid", int'(valid), 0);
      check("ovr_drain_cnt", got.size() - g0, 1);
      if (got.size() > g0) check("ovr_drain_data", int'(got[g0]), 8'h3C);

      // Start-bit glitch of 3 clocks
      f0 = nferr; v0 = vcyc;
      bl = 0;
      rx = 1'b0;
      repeat (3) begin
         tick();
         if (busy) bl++;
      end
      rx = 1'b1;
      repeat (20) begin
         tick();
         if (busy) bl++;
      end
      check("glitch_busy", int'(bl > 0 && bl <= HALF + 2), 1);
      check("glitch_valid", vcyc - v0, 0);
      check("glitch_ferr", nferr - f0, 0);
      check("glitch_idle", int'(busy), 0);

      // Framing error followed by a held-low line
      g0 = got.size(); f0 = nferr; v0 = vcyc;
      send_frame(8'h55, 1'b0);
      bl = 0;
      repeat (50) begin
         tick();
         if (!busy) bl++;
      end
      check("ferr_pulse", nferr - f0, 1);
      check("ferr_valid", vcyc - v0, 0);
      check("ferr_stay_busy", bl, 0);
      idle(10);
      check("ferr_recover", int'(busy), 0);
      send_frame(8'h12, 1'b1);
      idle(15);
      check("ferr_next_cnt", got.size() - g0, 1);
      if (got.size() > g0) check("ferr_next_data", int'(got[g0]), 8'h12);

      // Reset in the middle of data bit 4 (line low)
      g0 = got.size(); f0 = nferr; o0 = novr;
      fork
         send_frame(8'hEF, 1'b1);
         begin
            repeat (55) tick();
            reset = 1'b1;
            #1;
            check("mid_rst_rx", int'(rx), 0);
            check("mid_rst_data", int'(data), 0);
            check("mid_rst_valid", int'(valid), 0);
            check("mid_rst_busy", int'(busy), 1);
            check("mid_rst_flags", int'({frame_err, overrun}), 0);
            repeat (3) tick();
            reset = 1'b0;
         end
      join
      idle(20);
      check("mid_rst_nobyte", got.size() - g0, 0);
      check("mid_rst_ferr", nferr - f0, 0);
      check("mid_rst_ovr", novr - o0, 0);
      send_frame(8'h81, 1'b1);
      idle(15);
      check("mid_rst_next_cnt", got.size() - g0, 1);
      if (got.size() > g0) check("mid_rst_next", int'(got[g0]), 8'h81);

      // Ready lands on the same edge as the next good stop sample
      ready = 1'b0;
      send_frame(8'h11, 1'b1);
      idle(10);
      check("hold_valid", int'(valid), 1);
      check("hold_data", int'(data), 8'h11);
      g0 = got.size(); o0 = novr;
      fork
         send_frame(8'h7E, 1'b1);
         begin
            repeat (97) tick();
            ready = 1'b1;
            tick();
            ready = 1'b0;
         end
      join
      idle(5);
      check("swap_valid", int'(valid), 1);
      check("swap_data", int'(data), 8'h7E);
      check("swap_ovr", novr - o0, 0);
      check("swap_cnt", got.size() - g0, 1);
      if (got.size() > g0) check("swap_old", int'(got[g0]), 8'h11);
      ready = 1'b1;
      tick();
      check("swap_drain", int'(valid), 0);

      // Random frames against a queue of expected bytes
      idle(10);
      g0 = got.size(); f0 = nferr; o0 = novr;
      efe = 0;
      expq.delete();
      for (int k = 0; k < 24; k++) begin
         b  = 8'($urandom);
         st = ($urandom_range(0, 4) != 0);
         send_frame(b, st);
         if (st) begin
            expq.push_back(b);
            idle(int'($urandom_range(0, 12)));
         end else begin
            efe++;
            idle(5 + int'($urandom_range(0, 8)));
         end
      end
      idle(20);
      check("rnd_cnt", got.size() - g0, expq.size());
      for (int i = 0; i < expq.size() && g0 + i < got.size(); i++)
         check($sformatf("rnd_byte%0d", i), int'(got[g0 + i]), int'(expq[i]));
      check("rnd_ferr", nferr - f0, efe);
      check("rnd_ovr", novr - o0, 0);
      check("never_both", nboth, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
